// File: rtl/vga_scroll_controller.sv
// vga_scroll_controller
//   Avalon-MM slave that sequences the background vertical scroll offset.
//   The offset advances by a programmable step every N frames and wraps
//   modulo a programmable limit. Every change to the offset, whether an
//   automatic step or a CPU load, is applied only at frame start, which is
//   the falling edge of vsync_n.
// Ports
//   clk, reset_n     system clock, asynchronous active-low reset
//   address[1:0]     register select: 0 CTRL, 1 SPEED, 2 LIMIT, 3 OFFSET
//   chipselect       Avalon select
//   write_n          Avalon write strobe, active-low
//   writedata[31:0]  Avalon write data
//   readdata[31:0]   Avalon read data, combinational, zero wait-state
//   vsync_n          VGA vertical sync, active-low, asynchronous to clk
//   offset_out       current background offset for the renderer
//   frame_tick       one-clock pulse whenever offset_out is updated
module vga_scroll_controller #(
  parameter int OFFSET_W      = 10,
  parameter int DEFAULT_LIMIT = 480
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic                vsync_n,
  output logic [OFFSET_W-1:0] offset_out,
  output logic                frame_tick
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_r, state_next_s;
  logic                dir_r;
  logic [OFFSET_W-1:0] step_r;
  logic [7:0]          div_r;
  logic [OFFSET_W-1:0] limit_r;
  logic [OFFSET_W-1:0] pending_r;
  logic                load_pending_r;
  logic                step_err_r;
  logic [7:0]          frame_cnt_r, frame_cnt_next_s;
  logic [OFFSET_W-1:0] offset_r, offset_next_s;
  logic                frame_tick_r, tick_next_s;
  logic                sync1_r, sync2_r, sync3_r;

  logic                wr_s, ctrl_wr_s, frame_edge_s, step_due_s;
  logic                load_done_s, err_set_s;
  logic [OFFSET_W:0]   sum_s;
  logic [OFFSET_W-1:0] step_next_s;
  logic                unused_s;

  assign wr_s         = chipselect & ~write_n;
  assign ctrl_wr_s    = wr_s & (address == 2'd0);
  assign frame_edge_s = sync3_r & ~sync2_r;
  // div of 0 behaves as 1; ">=" also recovers promptly if div is lowered mid-count
  assign step_due_s   = (div_r == 8'd0) || (frame_cnt_r >= (div_r - 8'd1));
  assign offset_out   = offset_r;
  assign frame_tick   = frame_tick_r;
  assign unused_s     = ^{writedata[31:24], writedata[15:OFFSET_W]};

  // Three-flop synchroniser for vsync_n; idles high so reset never fakes an edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      sync3_r <= 1'b1;
    end else begin
      sync1_r <= vsync_n;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Wrapped step result; operands are assumed below limit, so results fit OFFSET_W bits
  always_comb begin
    sum_s       = {1'b0, offset_r} + {1'b0, step_r};
    step_next_s = offset_r;
    if (dir_r == 1'b0) begin
      if (sum_s >= {1'b0, limit_r}) begin
        step_next_s = offset_r + step_r - limit_r;
      end else begin
        step_next_s = offset_r + step_r;
      end
    end else begin
      if (offset_r < step_r) begin
        step_next_s = offset_r + limit_r - step_r;
      end else begin
        step_next_s = offset_r - step_r;
      end
    end
  end

  // Frame-edge evaluation on pre-write values, then CTRL enable write applied on top
  always_comb begin
    state_next_s     = state_r;
    offset_next_s    = offset_r;
    tick_next_s      = 1'b0;
    frame_cnt_next_s = frame_cnt_r;
    load_done_s      = 1'b0;
    err_set_s        = 1'b0;
    if (frame_edge_s) begin
      if (load_pending_r) begin
        if (pending_r >= limit_r) begin
          offset_next_s = {OFFSET_W{1'b0}};
        end else begin
          offset_next_s = pending_r;
        end
        tick_next_s      = 1'b1;
        frame_cnt_next_s = 8'd0;
        load_done_s      = 1'b1;
      end else begin
        case (state_r)
          ST_RUN: begin
            if (step_due_s) begin
              frame_cnt_next_s = 8'd0;
              if ((limit_r == {OFFSET_W{1'b0}}) || (step_r >= limit_r)) begin
                err_set_s = 1'b1;
              end else if (step_r != {OFFSET_W{1'b0}}) begin
                offset_next_s = step_next_s;
                tick_next_s   = 1'b1;
              end else begin
                offset_next_s = offset_r;
              end
            end else begin
              frame_cnt_next_s = frame_cnt_r + 8'd1;
            end
          end
          ST_IDLE: frame_cnt_next_s = 8'd0;
          default: frame_cnt_next_s = 8'd0;
        endcase
      end
    end else begin
      frame_cnt_next_s = frame_cnt_r;
    end
    if (ctrl_wr_s) begin
      if (writedata[0]) begin
        state_next_s = ST_RUN;
      end else begin
        state_next_s     = ST_IDLE;
        frame_cnt_next_s = 8'd0;
      end
    end else begin
      state_next_s = state_r;
    end
  end

  // Sequencer state, frame counter and the registered renderer outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      frame_cnt_r  <= 8'd0;
      offset_r     <= {OFFSET_W{1'b0}};
      frame_tick_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      frame_cnt_r  <= frame_cnt_next_s;
      offset_r     <= offset_next_s;
      frame_tick_r <= tick_next_s;
    end
  end

  // Register file; CPU writes come after edge side-effects so a same-cycle write wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_r          <= 1'b0;
      step_r         <= OFFSET_W'(1);
      div_r          <= 8'd1;
      limit_r        <= OFFSET_W'(DEFAULT_LIMIT);
      pending_r      <= {OFFSET_W{1'b0}};
      load_pending_r <= 1'b0;
      step_err_r     <= 1'b0;
    end else begin
      if (load_done_s) load_pending_r <= 1'b0;
      if (err_set_s) step_err_r <= 1'b1;
      if (wr_s) begin
        case (address)
          2'd0: begin
            dir_r <= writedata[1];
            if (writedata[2]) load_pending_r <= 1'b1;
            if (writedata[4]) step_err_r <= 1'b0;
          end
          2'd1: begin
            step_r <= writedata[OFFSET_W-1:0];
            div_r  <= writedata[23:16];
          end
          2'd2: limit_r <= writedata[OFFSET_W-1:0];
          2'd3: begin
            pending_r      <= writedata[OFFSET_W-1:0];
            load_pending_r <= 1'b1;
          end
          default: pending_r <= pending_r;
        endcase
      end
    end
  end

  // Zero wait-state read mux; unused bits read as zero
  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0: readdata[4:0] = {step_err_r, load_pending_r, 1'b0, dir_r, (state_r == ST_RUN)};
      2'd1: begin
        readdata[OFFSET_W-1:0] = step_r;
        readdata[23:16]        = div_r;
      end
      2'd2: readdata[OFFSET_W-1:0] = limit_r;
      2'd3: readdata[OFFSET_W-1:0] = offset_r;
      default: readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_vga_scroll_controller.sv
module tb_vga_scroll_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        vsync_n;
  logic [9:0]  offset_out;
  logic        frame_tick;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state (plain integers, modular arithmetic)
  int m_en, m_dir, m_step, m_div, m_limit, m_pending, m_lp, m_err, m_offset, m_frames;
  int e_prev, e_off, e_tick;

  // observations from one frame
  logic [9:0]  o_pre_off, o_off;
  logic        o_pre_tick, o_tick, o_post;
  logic [31:0] rd;

  vga_scroll_controller #(.OFFSET_W(10), .DEFAULT_LIMIT(480)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .vsync_n(vsync_n), .offset_out(offset_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic void model_reset();
    m_en = 0; m_dir = 0; m_step = 1; m_div = 1; m_limit = 480;
    m_pending = 0; m_lp = 0; m_err = 0; m_offset = 0; m_frames = 0;
  endfunction

  function automatic void model_write(input logic [1:0] a, input logic [31:0] d);
    case (a)
      2'd0: begin
        m_en = int'(d[0]); m_dir = int'(d[1]);
        if (!d[0]) m_frames = 0;
        if (d[2]) m_lp = 1;
        if (d[4]) m_err = 0;
      end
      2'd1: begin m_step = int'(d[9:0]); m_div = int'(d[23:16]); end
      2'd2: m_limit = int'(d[9:0]);
      default: begin m_pending = int'(d[9:0]); m_lp = 1; end
    endcase
  endfunction

  // one frame start: a pending load wins, otherwise step once every div frames
  function automatic void model_edge();
    int dv;
    e_prev = m_offset;
    e_tick = 0;
    dv = (m_div == 0) ? 1 : m_div;
    if (m_lp != 0) begin
      m_offset = (m_pending >= m_limit) ? 0 : m_pending;
      m_lp = 0; e_tick = 1; m_frames = 0;
    end else if (m_en != 0) begin
      m_frames++;
      if (m_frames >= dv) begin
        m_frames = 0;
        if (m_limit == 0 || m_step >= m_limit) m_err = 1;
        else if (m_step != 0) begin
          if (m_dir != 0) m_offset = (m_offset + m_limit - m_step) % m_limit;
          else            m_offset = (m_offset + m_step) % m_limit;
          e_tick = 1;
        end
      end
    end
    e_off = m_offset;
  endfunction

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    model_write(a, d);
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1 d = readdata;
    chipselect = 1'b0;
  endtask

  // vsync pulse; optional CPU write lands on the same clock as the frame edge
  task automatic frame(input bit with_wr, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk) vsync_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    o_pre_off = offset_out; o_pre_tick = frame_tick;
    if (with_wr) begin
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    end
    model_edge();
    @(posedge clk); #1;
    o_off = offset_out; o_tick = frame_tick;
    @(negedge clk);
    vsync_n = 1'b1;
    if (with_wr) begin
      chipselect = 1'b0; write_n = 1'b1;
      model_write(a, d);
    end
    @(posedge clk); #1 o_post = frame_tick;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] want [4];
    want[0] = 32'h0; want[1] = 32'h0001_0001; want[2] = 32'd480; want[3] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      cpu_read(2'(i), rd);
      n_checks++;
      if (rd !== want[i]) $display("FAIL reset_reg%0d: got %h want %h", i, rd, want[i]);
      else n_pass++;
    end
    n_checks++;
    if ({offset_out, frame_tick} !== 11'd0) $display("FAIL reset_out: offset=%0d tick=%b want 0/0", offset_out, frame_tick);
    else n_pass++;
  endtask

  task automatic test_step();
    cpu_write(2'd1, 32'h0001_0004);
    cpu_write(2'd0, 32'h1);
    for (int i = 1; i <= 3; i++) begin
      frame(1'b0, 2'd0, 32'd0);
      n_checks++;
      if (o_pre_off !== 10'(e_prev) || o_pre_tick !== 1'b0 || o_off !== 10'(4 * i) ||
          o_tick !== 1'b1 || o_post !== 1'b0)
        $display("FAIL step%0d: off=%0d tick=%b pre=%0d/%b post=%b want off=%0d tick=1", i, o_off, o_tick, o_pre_off, o_pre_tick, o_post, 4 * i);
      else n_pass++;
    end
  endtask

  task automatic test_wrap_dir_div();
    logic [31:0] wr [5];
    int nf [5];
    wr[0] = 32'd478;       nf[0] = 1;  // load 478 (address 3)
    wr[1] = 32'h1;         nf[1] = 1;  // dir + : 478 -> 2
    wr[2] = 32'h3;         nf[2] = 1;  // dir - : 2 -> 478
    wr[3] = 32'h0003_0004; nf[3] = 0;  // div = 3
    wr[4] = 32'h1;         nf[4] = 3;  // dir + : step on 3rd frame only
    for (int k = 0; k < 5; k++) begin
      cpu_write((k == 0) ? 2'd3 : ((k == 3) ? 2'd1 : 2'd0), wr[k]);
      for (int f = 0; f < nf[k]; f++) begin
        frame(1'b0, 2'd0, 32'd0);
        n_checks++;
        if (o_pre_off !== 10'(e_prev) || o_pre_tick !== 1'b0 || o_off !== 10'(e_off) ||
            o_tick !== 1'(e_tick) || o_post !== 1'b0)
          $display("FAIL wrap k%0d f%0d: off=%0d tick=%b pre=%0d/%b post=%b want off=%0d tick=%0d", k, f, o_off, o_tick, o_pre_off, o_pre_tick, o_post, e_off, e_tick);
        else n_pass++;
      end
    end
    n_checks++;
    if (offset_out !== 10'd2) $display("FAIL wrap_final: offset=%0d want 2", offset_out);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    cpu_write(2'd1, 32'h0001_0004);
    frame(1'b1, 2'd3, 32'd100);
    n_checks++;
    if (o_off !== 10'd6 || o_tick !== 1'b1 || o_off !== 10'(e_off))
      $display("FAIL same_cycle_step: off=%0d tick=%b want 6/1", o_off, o_tick);
    else n_pass++;
    frame(1'b0, 2'd0, 32'd0);
    n_checks++;
    if (o_off !== 10'd100 || o_tick !== 1'b1 || o_off !== 10'(e_off))
      $display("FAIL deferred_load: off=%0d tick=%b want 100/1", o_off, o_tick);
    else n_pass++;
  endtask

  task automatic test_step_err();
    cpu_write(2'd1, 32'h0001_01E0);
    frame(1'b0, 2'd0, 32'd0);
    n_checks++;
    if (o_off !== 10'd100 || o_tick !== 1'b0 || o_post !== 1'b0)
      $display("FAIL err_hold: off=%0d tick=%b want 100/0", o_off, o_tick);
    else n_pass++;
    cpu_read(2'd0, rd);
    n_checks++;
    if (rd !== 32'h11) $display("FAIL err_flag: ctrl=%h want 00000011", rd);
    else n_pass++;
    cpu_write(2'd0, 32'h11);
    cpu_read(2'd0, rd);
    n_checks++;
    if (rd !== 32'h01) $display("FAIL err_clear: ctrl=%h want 00000001", rd);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    cpu_write(2'd1, 32'h0001_0007);
    frame(1'b0, 2'd0, 32'd0);
    @(negedge clk) vsync_n = 1'b0;
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) begin reset_n = 1'b1; vsync_n = 1'b1; end
    model_reset();
    #1;
    n_checks++;
    if (offset_out !== 10'd0 || frame_tick !== 1'b0)
      $display("FAIL midrst_out: offset=%0d tick=%b want 0/0", offset_out, frame_tick);
    else n_pass++;
    cpu_read(2'd0, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL midrst_ctrl: ctrl=%h want 00000000", rd);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      frame(1'b0, 2'd0, 32'd0);
      n_checks++;
      if (o_off !== 10'd0 || o_tick !== 1'b0 || o_post !== 1'b0)
        $display("FAIL midrst_idle%0d: off=%0d tick=%b want 0/0", i, o_off, o_tick);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    cpu_write(2'd0, 32'h1);
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(3, 0) == 0) begin
        d = 32'd0;
        d[9:0]   = 10'($urandom_range(m_limit, 0));
        d[23:16] = 8'($urandom_range(3, 0));
        cpu_write(2'd1, d);
      end
      if ($urandom_range(3, 0) == 0) cpu_write(2'd2, 32'($urandom_range(1023, m_offset + 1)));
      if ($urandom_range(4, 0) == 0) cpu_write(2'd3, 32'($urandom_range(1023, 0)));
      if ($urandom_range(4, 0) == 0) cpu_write(2'd0, 32'($urandom_range(31, 0)) | 32'h1);
      frame(1'b0, 2'd0, 32'd0);
      n_checks++;
      if (o_pre_off !== 10'(e_prev) || o_pre_tick !== 1'b0 || o_off !== 10'(e_off) ||
          o_tick !== 1'(e_tick) || o_post !== 1'b0)
        $display("FAIL rand%0d: off=%0d tick=%b pre=%0d/%b post=%b want off=%0d tick=%0d", it, o_off, o_tick, o_pre_off, o_pre_tick, o_post, e_off, e_tick);
      else n_pass++;
      cpu_read(2'd0, rd);
      n_checks++;
      if (rd !== 32'(m_err * 16 + m_lp * 8 + m_dir * 2 + m_en))
        $display("FAIL rand_ctrl%0d: ctrl=%h want %h", it, rd, 32'(m_err * 16 + m_lp * 8 + m_dir * 2 + m_en));
      else n_pass++;
      cpu_read(2'd1, rd);
      n_checks++;
      if (rd !== 32'(m_div * 65536 + m_step))
        $display("FAIL rand_speed%0d: speed=%h want %h", it, rd, 32'(m_div * 65536 + m_step));
      else n_pass++;
    end
  endtask

  initial begin
    reset_n = 1'b0; vsync_n = 1'b1; address = 2'd0; chipselect = 1'b0;
    write_n = 1'b1; writedata = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_step();
    test_wrap_dir_div();
    test_back_to_back();
    test_step_err();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
